// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word type, fetch constants, FSM states, queue entry layout and PC legality helper
package cpu_pkg;
    typedef logic [31:0] word_t;
    localparam word_t INSTR_BYTES = 32'd4;
    typedef enum logic {FS_RUN, FS_FAULT} fetch_state_t;
    typedef struct packed {
        word_t pc;
        word_t data;
    } fetch_entry_t;
    // A fetch PC is legal when word aligned and the whole word lies inside the ROM
    function automatic logic pc_legal(word_t pc, word_t rom_size);
        return (pc[1:0] == 2'b00) && (pc <= rom_size - INSTR_BYTES);
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc,data} fetch entries with push, pop, flush and occupancy count
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset, empties the queue
//   flush      in   empties the queue, overrides same-cycle push/pop
//   push       in   write push_entry at the tail
//   push_entry in   {pc,data} entry to store
//   pop        in   advance the head (ignored when empty)
//   count      out  number of stored entries
//   head_valid out  queue not empty
//   head_entry out  oldest entry, zero when empty
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output fetch_entry_t             head_entry
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic do_push, do_pop;
    assign head_valid = count != '0;
    assign do_pop     = pop & head_valid;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign do_push    = push & ((count != CW'(DEPTH)) | do_pop);
    assign head_entry = head_valid ? mem[head] : '0;
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_entry;
                tail      <= tail + 1'b1;
            end
            if (do_pop)
                head <= head + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch from a 1-cycle ROM into a prefetch queue feeding decode
//   mclk           in   clock, all state on rising edge
//   rst_n          in   synchronous active-low reset
//   rom_enable     out  fetch request to ROM this cycle
//   rom_address    out  byte address of the requested word
//   rom_data_in    in   ROM word, valid the cycle after rom_enable
//   redirect_valid in   branch/exception redirect pulse
//   redirect_pc    in   new fetch PC
//   instr_valid    out  queue head valid
//   instr_data     out  queue head instruction word
//   instr_pc       out  PC of queue head
//   instr_ready    in   decode accepts the head this cycle
//   fetch_fault    out  sticky misaligned/out-of-range PC flag
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC    = 32'h0000_0000,
    parameter int    QUEUE_DEPTH = 2,
    parameter int    ROM_SIZE    = 64000
)(
    input  logic  mclk,
    input  logic  rst_n,
    output logic  rom_enable,
    output word_t rom_address,
    input  word_t rom_data_in,
    input  logic  redirect_valid,
    input  word_t redirect_pc,
    output logic  instr_valid,
    output word_t instr_data,
    output word_t instr_pc,
    input  logic  instr_ready,
    output logic  fetch_fault
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    fetch_state_t state;
    word_t pc, inflight_pc;
    logic inflight, pc_ok, pop, room;
    logic [CW-1:0] count;
    fetch_entry_t head, reply;
    assign pc_ok = pc_legal(pc, word_t'(ROM_SIZE));
    assign pop   = instr_valid & instr_ready;
    // Capacity counts the head leaving this cycle and the reply still on its way
    assign room  = (count - CW'(pop) + CW'(inflight)) < CW'(QUEUE_DEPTH);
    assign rom_enable  = rst_n & (state == FS_RUN) & ~redirect_valid & pc_ok & room;
    assign rom_address = pc;
    assign reply       = '{pc: inflight_pc, data: rom_data_in};
    assign instr_pc    = head.pc;
    assign instr_data  = head.data;
    // A redirect flushes the queue, which also drops the reply arriving this cycle
    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk        (mclk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (inflight),
        .push_entry (reply),
        .pop        (pop),
        .count      (count),
        .head_valid (instr_valid),
        .head_entry (head)
    );
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            state       <= FS_RUN;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            state       <= FS_RUN;
            inflight    <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            inflight <= rom_enable;
            if (rom_enable) begin
                pc          <= pc + INSTR_BYTES;
                inflight_pc <= pc;
            end
            if (state == FS_RUN && !pc_ok) begin
                state       <= FS_FAULT;
                fetch_fault <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench with a ROM model and an in-order fetch stream reference
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam int          ROM      = 64000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_enable;
    logic [31:0] rom_address;
    logic [31:0] rom_data_in = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;
    localparam logic [1:0] EV_INSTR = 2'd0, EV_REQ = 2'd1, EV_REDIR = 2'd2, EV_RESET = 2'd3;
    ev_t log_q[$];

    instr_fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH), .ROM_SIZE(ROM)) dut (
        .mclk           (mclk),
        .rst_n          (rst_n),
        .rom_enable     (rom_enable),
        .rom_address    (rom_address),
        .rom_data_in    (rom_data_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fetch_fault    (fetch_fault)
    );

    always #5 mclk = ~mclk;

    function automatic logic [31:0] rom_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ROM: word appears the cycle after the request, garbage otherwise
    always @(posedge mclk)
        rom_data_in <= rom_enable ? rom_word(rom_address) : $urandom();

    // Event recorder: redirect/reset markers, requests and accepted instructions in cycle order
    always @(negedge mclk) begin
        if (!rst_n)
            log_q.push_back({EV_RESET, RESET_PC, 32'd0});
        else begin
            if (redirect_valid)
                log_q.push_back({EV_REDIR, redirect_pc, 32'd0});
            if (rom_enable)
                log_q.push_back({EV_REQ, rom_address, 32'd0});
            if (instr_valid && instr_ready && !redirect_valid)
                log_q.push_back({EV_INSTR, instr_pc, instr_data});
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!instr_valid && k < 20) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_ready = 1'b1;
        tick();
        tick();
        checks++; if (rom_enable !== 1'b0) begin failures++; $display("FAIL reset_rom_enable got=%b exp=0", rom_enable); end
        checks++; if (rom_address !== RESET_PC) begin failures++; $display("FAIL reset_rom_address got=%h exp=%h", rom_address, RESET_PC); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        checks++; if (instr_data !== 32'd0) begin failures++; $display("FAIL reset_instr_data got=%h exp=0", instr_data); end
        checks++; if (instr_pc !== 32'd0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fetch_fault got=%b exp=0", fetch_fault); end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        @(negedge mclk);
        checks++; if (rom_enable !== 1'b1 || rom_address !== RESET_PC) begin failures++; $display("FAIL stream_first_req en=%b addr=%h exp en=1 addr=%h", rom_enable, rom_address, RESET_PC); end
        tick();
        checks++; if (instr_valid !== 1'b0 || rom_address !== RESET_PC + 4) begin failures++; $display("FAIL stream_edge1 valid=%b addr=%h exp valid=0 addr=%h", instr_valid, rom_address, RESET_PC + 4); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr_data !== rom_word(RESET_PC)) begin failures++; $display("FAIL stream_latency valid=%b pc=%h data=%h exp valid=1 pc=%h data=%h", instr_valid, instr_pc, instr_data, RESET_PC, rom_word(RESET_PC)); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC + 4 * i || instr_data !== rom_word(RESET_PC + 4 * i)) begin failures++; $display("FAIL stream_rate[%0d] valid=%b pc=%h exp pc=%h", i, instr_valid, instr_pc, RESET_PC + 4 * i); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        rst_n = 1'b0;
        instr_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge mclk);
            n += int'(rom_enable);
            tick();
        end
        checks++; if (n != DEPTH) begin failures++; $display("FAIL bp_request_count got=%0d exp=%0d", n, DEPTH); end
        checks++; if (rom_enable !== 1'b0) begin failures++; $display("FAIL bp_stalled_enable got=%b exp=0", rom_enable); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin failures++; $display("FAIL bp_head_hold valid=%b pc=%h exp pc=%h", instr_valid, instr_pc, RESET_PC); end
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC + 4 * i || instr_data !== rom_word(RESET_PC + 4 * i)) begin failures++; $display("FAIL bp_drain[%0d] valid=%b pc=%h exp pc=%h", i, instr_valid, instr_pc, RESET_PC + 4 * i); end
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        int k;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge mclk);
        checks++; if (rom_enable !== 1'b0) begin failures++; $display("FAIL redir_no_issue got=%b exp=0", rom_enable); end
        tick();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush valid=%b exp=0", instr_valid); end
        wait_valid(k);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_data !== rom_word(32'h40)) begin failures++; $display("FAIL redir_target valid=%b pc=%h exp pc=00000040 wait=%0d", instr_valid, instr_pc, k); end
    endtask

    task automatic test_fault_redirect();
        int n = 0;
        int k;
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        checks++; if (rom_enable !== 1'b0) begin failures++; $display("FAIL fault_misaligned_req got=%b exp=0", rom_enable); end
        tick();
        checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL fault_set got=%b exp=1", fetch_fault); end
        repeat (5) begin
            @(negedge mclk);
            n += int'(rom_enable);
            tick();
        end
        checks++; if (n != 0 || fetch_fault !== 1'b1) begin failures++; $display("FAIL fault_halted reqs=%0d fault=%b exp reqs=0 fault=1", n, fetch_fault); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", fetch_fault); end
        wait_valid(k);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr_data !== rom_word(32'h10)) begin failures++; $display("FAIL fault_recover pc=%h valid=%b exp pc=00000010", instr_pc, instr_valid); end
    endtask

    task automatic test_end_of_rom();
        logic [31:0] last_pc = '0;
        logic [31:0] max_addr = '0;
        int k = 0;
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = ROM - 64;
        tick();
        redirect_valid = 1'b0;
        while (k < 200) begin
            @(negedge mclk);
            if (instr_valid && instr_ready) last_pc = instr_pc;
            if (rom_enable && rom_address > max_addr) max_addr = rom_address;
            if (fetch_fault && !instr_valid) break;
            tick();
            k++;
        end
        tick();
        checks++; if (last_pc !== ROM - 4) begin failures++; $display("FAIL eor_last_pc got=%h exp=%h", last_pc, ROM - 4); end
        checks++; if (max_addr !== ROM - 4) begin failures++; $display("FAIL eor_max_req got=%h exp=%h", max_addr, ROM - 4); end
        checks++; if (fetch_fault !== 1'b1 || rom_enable !== 1'b0) begin failures++; $display("FAIL eor_fault fault=%b en=%b exp fault=1 en=0", fetch_fault, rom_enable); end
    endtask

    task automatic test_reset_midstream();
        int k;
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin failures++; $display("FAIL rst_mid_full valid=%b pc=%h exp pc=00000100", instr_valid, instr_pc); end
        instr_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_empty valid=%b exp=0", instr_valid); end
        @(negedge mclk);
        checks++; if (rom_enable !== 1'b1 || rom_address !== RESET_PC) begin failures++; $display("FAIL rst_mid_req en=%b addr=%h exp en=1 addr=%h", rom_enable, rom_address, RESET_PC); end
        tick();
        wait_valid(k);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr_data !== rom_word(RESET_PC)) begin failures++; $display("FAIL rst_mid_stale pc=%h data=%h exp pc=%h data=%h", instr_pc, instr_data, RESET_PC, rom_word(RESET_PC)); end
    endtask

    task automatic test_random();
        logic pv_valid = 1'b0, pv_ready = 1'b1, pv_redir = 1'b0;
        logic [31:0] ppc = '0, pdata = '0;
        for (int c = 0; c < 800; c++) begin
            if (pv_valid && !pv_ready && !pv_redir) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== ppc || instr_data !== pdata) begin failures++; $display("FAIL rand_hold cyc=%0d valid=%b pc=%h data=%h exp pc=%h data=%h", c, instr_valid, instr_pc, instr_data, ppc, pdata); end
            end
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            if (redirect_valid)
                redirect_pc = ($urandom_range(0, 7) == 0) ? 4 * $urandom_range(0, 300) + 2 : 4 * $urandom_range(0, 300);
            pv_valid = instr_valid;
            pv_ready = instr_ready;
            pv_redir = redirect_valid;
            ppc = instr_pc;
            pdata = instr_data;
            tick();
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        tick();
    endtask

    // Reference: after any reset or redirect, requests and delivered instructions are
    // each a gap-free ascending word sequence starting at the new target
    task automatic test_scoreboard();
        logic [31:0] exp_i = RESET_PC;
        logic [31:0] exp_r = RESET_PC;
        int ni = 0;
        foreach (log_q[i]) begin
            case (log_q[i].kind)
                EV_RESET, EV_REDIR: begin
                    exp_i = log_q[i].a;
                    exp_r = log_q[i].a;
                end
                EV_REQ: begin
                    checks++; if (log_q[i].a !== exp_r) begin failures++; $display("FAIL sb_request idx=%0d addr=%h exp=%h", i, log_q[i].a, exp_r); end
                    exp_r = log_q[i].a + 4;
                end
                default: begin
                    ni++;
                    checks++; if (log_q[i].a !== exp_i || log_q[i].d !== rom_word(log_q[i].a)) begin failures++; $display("FAIL sb_instr idx=%0d pc=%h data=%h exp pc=%h data=%h", i, log_q[i].a, log_q[i].d, exp_i, rom_word(exp_i)); end
                    exp_i = log_q[i].a + 4;
                end
            endcase
        end
        checks++; if (ni < 200) begin failures++; $display("FAIL sb_volume instrs=%0d exp>=200", ni); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_fault_redirect();
        test_end_of_rom();
        test_reset_midstream();
        test_random();
        test_scoreboard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
